// File: rtl/ocd_lvl_mc.sv
// Multi-channel overcurrent-threshold level generator.
// One shared period counter drives CH_NUM outputs that run either as
// phase-staggered PWM or as first-order sigma-delta. Duty codes are
// double-buffered (shadow -> active) and both the duty codes and the
// mode switch take effect only at the period boundary.
module ocd_lvl_mc #(
  parameter int CLK_MHZ       = 100,
  parameter int PAR_MAX_VAL   = 255,
  parameter int CH_NUM        = 2,
  parameter int PHASE_STAGGER = 1,
  localparam int W            = $clog2(PAR_MAX_VAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_NUM*W-1:0] pw_par,
  input  logic [CH_NUM-1:0]   upd,
  input  logic                mode,
  output logic [CH_NUM-1:0]   out,
  output logic                period_tick
);

  // Nominal output frequency, kept for reference only.
  localparam int FREQ_KHZ = 1000 * CLK_MHZ / PAR_MAX_VAL;

  localparam logic [W-1:0] MAXV    = W'(PAR_MAX_VAL);
  localparam logic [W:0]   MAXV_X  = (W + 1)'(PAR_MAX_VAL);
  localparam logic [W-1:0] CNT_TOP = W'(PAR_MAX_VAL - 1);

  // Reject configurations the counter and wrap arithmetic cannot support.
  if (PAR_MAX_VAL < 2 || CH_NUM < 1 || FREQ_KHZ < 0) begin : g_bad_param
    $error("ocd_lvl_mc: PAR_MAX_VAL must be >= 2 and CH_NUM >= 1");
  end

  // Saturate a captured duty code to full scale.
  function automatic logic [W-1:0] f_sat(input logic [W-1:0] v);
    if ({1'b0, v} > MAXV_X) begin
      return MAXV;
    end
    return v;
  endfunction

  // Fixed phase offset of channel k inside the period.
  function automatic logic [W-1:0] f_off(input int k);
    return (PHASE_STAGGER != 0) ? W'(k * PAR_MAX_VAL / CH_NUM) : '0;
  endfunction

  // (c + off) mod PAR_MAX_VAL; both operands are below PAR_MAX_VAL, so one
  // conditional subtract in W+1 bits covers the whole range without overflow.
  function automatic logic [W-1:0] f_wrap_add(input logic [W-1:0] c,
                                              input logic [W-1:0] off);
    logic [W:0] sum;
    sum = {1'b0, c} + {1'b0, off};
    if (sum >= MAXV_X) begin
      sum = sum - MAXV_X;
    end
    return sum[W-1:0];
  endfunction

  logic [W-1:0]      r_cnt;
  logic              r_mode_act;
  logic              r_tick;
  logic [W-1:0]      r_shadow [CH_NUM];
  logic [W-1:0]      r_active [CH_NUM];
  logic [W-1:0]      r_acc    [CH_NUM];
  logic [CH_NUM-1:0] r_out_p1;

  logic              w_wrap;
  logic [W-1:0]      w_code    [CH_NUM];
  logic [W-1:0]      w_phase   [CH_NUM];
  logic [W:0]        w_sum     [CH_NUM];
  logic [W-1:0]      w_acc_nxt [CH_NUM];
  logic [CH_NUM-1:0] w_out_p0;

  assign w_wrap = (r_cnt == '0);

  // Stage p0: per-channel level decision from the current counter and active duty.
  always_comb begin
    w_out_p0 = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_code[k]    = f_sat(pw_par[k*W +: W]);
      w_phase[k]   = f_wrap_add(r_cnt, f_off(k));
      w_sum[k]     = {1'b0, r_acc[k]} + {1'b0, r_active[k]};
      w_acc_nxt[k] = w_sum[k][W-1:0];
      if (r_mode_act) begin
        // Sigma-delta: emit a one on every carry past full scale.
        if (w_sum[k] >= MAXV_X) begin
          w_out_p0[k]  = 1'b1;
          w_acc_nxt[k] = W'(w_sum[k] - MAXV_X);
        end
      end else begin
        w_out_p0[k] = (w_phase[k] < r_active[k]);
      end
    end
  end

  // Stage p1: counter, buffered duty codes, mode, accumulators and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= CNT_TOP;
      r_mode_act <= 1'b0;
      r_tick     <= 1'b0;
      r_out_p1   <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
        r_acc[k]    <= '0;
      end
    end else begin
      r_cnt    <= w_wrap ? CNT_TOP : r_cnt - 1'b1;
      r_tick   <= w_wrap;
      r_out_p1 <= w_out_p0;
      if (w_wrap) begin
        r_mode_act <= mode;
      end
      for (int k = 0; k < CH_NUM; k++) begin
        if (upd[k]) begin
          r_shadow[k] <= w_code[k];
        end
        // An update landing on the wrap cycle bypasses the shadow so it
        // is not delayed by a whole period.
        if (w_wrap) begin
          r_active[k] <= upd[k] ? w_code[k] : r_shadow[k];
        end
        // The accumulator only runs in sigma-delta mode and is cleared when
        // leaving it, so a later return starts from a clean window.
        if (!r_mode_act) begin
          r_acc[k] <= '0;
        end else if (w_wrap && !mode) begin
          r_acc[k] <= '0;
        end else begin
          r_acc[k] <= w_acc_nxt[k];
        end
      end
    end
  end

  assign out         = r_out_p1;
  assign period_tick = r_tick;

endmodule

// File: tb/tb_ocd_lvl_mc.sv
// Bench for ocd_lvl_mc: two instances (aligned and staggered) share the
// stimulus and are compared every cycle against a period-level model.
module tb_ocd_lvl_mc;

  localparam int MAX = 10;
  localparam int CH  = 2;
  localparam int W   = 4;
  localparam int PW  = CH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pw_par;
  logic [CH-1:0] upd;
  logic          mode;
  logic [CH-1:0] out0, out1;
  logic          tick0, tick1;

  always #5 clk = ~clk;

  ocd_lvl_mc #(.CLK_MHZ(100), .PAR_MAX_VAL(MAX), .CH_NUM(CH), .PHASE_STAGGER(0)) u_dut0 (
    .clk(clk), .rst(rst), .pw_par(pw_par), .upd(upd), .mode(mode),
    .out(out0), .period_tick(tick0)
  );

  ocd_lvl_mc #(.CLK_MHZ(100), .PAR_MAX_VAL(MAX), .CH_NUM(CH), .PHASE_STAGGER(1)) u_dut1 (
    .clk(clk), .rst(rst), .pw_par(pw_par), .upd(upd), .mode(mode),
    .out(out1), .period_tick(tick1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: m_j is the index (1..MAX) of the next edge within the
  // period; edge MAX is the period boundary.
  int            m_j;
  int            m_sh  [CH];
  int            m_act [CH];
  logic          m_mode;
  logic [CH-1:0] m_out0, m_out1;
  logic          m_tick;

  logic [PW-1:0] cur_p;
  logic          cur_md;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  function automatic int f_off(input int k, input int stag);
    return (stag != 0) ? k * MAX / CH : 0;
  endfunction

  // Aligned PWM is high on the last a edges of the period; a staggered
  // channel is the aligned waveform delayed by its offset.
  function automatic logic f_pwm(input int j, input int a, input int off);
    int jj;
    jj = (((j - 1 - off) % MAX) + MAX) % MAX + 1;
    return (MAX - jj) < a;
  endfunction

  // Sigma-delta from a zero accumulator: floor(j*a/MAX) ones after j edges.
  function automatic logic f_sd(input int j, input int a);
    return ((j * a) / MAX - ((j - 1) * a) / MAX) != 0;
  endfunction

  task automatic model_edge();
    logic wrap;
    int   code;
    if (rst) begin
      m_j = 1; m_mode = 1'b0; m_out0 = '0; m_out1 = '0; m_tick = 1'b0;
      for (int k = 0; k < CH; k++) begin m_sh[k] = 0; m_act[k] = 0; end
    end else begin
      wrap = (m_j == MAX);
      for (int k = 0; k < CH; k++) begin
        m_out0[k] = m_mode ? f_sd(m_j, m_act[k]) : f_pwm(m_j, m_act[k], f_off(k, 0));
        m_out1[k] = m_mode ? f_sd(m_j, m_act[k]) : f_pwm(m_j, m_act[k], f_off(k, 1));
      end
      m_tick = wrap;
      for (int k = 0; k < CH; k++) begin
        code = int'(pw_par[k*W +: W]);
        if (code > MAX) code = MAX;
        if (wrap) m_act[k] = upd[k] ? code : m_sh[k];
        if (upd[k]) m_sh[k] = code;
      end
      if (wrap) m_mode = mode;
      m_j = wrap ? 1 : m_j + 1;
    end
  endtask

  task automatic step(input logic r, input logic [CH-1:0] u);
    rst = r; upd = u; pw_par = cur_p; mode = cur_md;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_aligned",   int'(out0),  int'(m_out0));
    chk("out_staggered", int'(out1),  int'(m_out1));
    chk("tick_aligned",  int'(tick0), int'(m_tick));
    chk("tick_staggered",int'(tick1), int'(m_tick));
  endtask

  task automatic set_codes(input int c0, input int c1, input logic [CH-1:0] u);
    cur_p[0 +: W] = W'(c0);
    cur_p[W +: W] = W'(c1);
    step(1'b0, u);
  endtask

  // Steps until a period tick is seen, bounded.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      step(1'b0, '0);
      n++;
    end while (!tick0 && n < 3 * MAX);
    chk(tag, int'(tick0), 1);
  endtask

  initial begin
    int c0, c1, t, n;
    logic [CH-1:0] ru;
    cur_p = '0; cur_md = 1'b0;

    // Reset state
    step(1'b1, '0);
    step(1'b1, '0);
    chk("rst_out", int'(out0), 0);
    chk("rst_tick", int'(tick0), 0);

    // Aligned PWM 3/7
    set_codes(3, 7, 2'b11);
    wait_tick("pwm_first_tick");
    c0 = 0; c1 = 0; t = 0;
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, '0);
      c0 += int'(out0[0]); c1 += int'(out0[1]); t += int'(tick0);
    end
    chk("pwm3_high", c0, 3);
    chk("pwm7_high", c1, 7);
    chk("tick_per_period", t, 1);
    chk("tick_at_period_end", int'(tick0), 1);

    // Stagger 5/5: staggered channels are complementary
    set_codes(5, 5, 2'b11);
    wait_tick("stag_tick_a");
    wait_tick("stag_tick_b");
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, '0);
      chk("stag_complement", int'(out1[0] ^ out1[1]), 1);
    end

    // Mid-period update and wrap-edge bypass
    set_codes(3, 3, 2'b11);
    wait_tick("upd_tick_a");
    wait_tick("upd_tick_b");
    c0 = 0;
    for (int i = 0; i < MAX; i++) begin
      if (i == 5) begin cur_p[0 +: W] = W'(8); step(1'b0, 2'b01); end
      else step(1'b0, '0);
      c0 += int'(out0[0]);
    end
    chk("upd_mid_keeps_old", c0, 3);
    c0 = 0;
    for (int i = 0; i < MAX; i++) begin
      if (i == MAX - 1) begin cur_p[0 +: W] = W'(2); step(1'b0, 2'b01); end
      else step(1'b0, '0);
      c0 += int'(out0[0]);
    end
    chk("upd_next_period", c0, 8);
    c0 = 0;
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, '0);
      c0 += int'(out0[0]);
    end
    chk("upd_wrap_bypass", c0, 2);

    // Boundary codes: 0 and clamped 15, then full scale 10
    set_codes(0, 15, 2'b11);
    wait_tick("bnd_tick_a");
    c0 = 0; c1 = 0;
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, '0);
      c0 += int'(out0[0]); c1 += int'(out1[1]);
    end
    chk("code0_low", c0, 0);
    chk("code15_clamped_high", c1, MAX);
    set_codes(10, 10, 2'b11);
    wait_tick("bnd_tick_b");
    c0 = 0;
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, '0);
      c0 += int'(out0[0]) + int'(out1[1]);
    end
    chk("code10_full", c0, 2 * MAX);

    // Sigma-delta with code 3, then back to PWM mid-period
    cur_md = 1'b1;
    set_codes(3, 6, 2'b11);
    wait_tick("sd_tick");
    c0 = 0; c1 = 0;
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, '0);
      c0 += int'(out0[0]); c1 += int'(out0[1]);
    end
    chk("sd3_ones", c0, 3);
    chk("sd6_ones", c1, 6);
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    cur_md = 1'b0;
    for (int i = 0; i < 2 * MAX; i++) step(1'b0, '0);

    // Reset mid-period
    wait_tick("rst_mid_tick");
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    step(1'b1, '0);
    chk("rst_mid_out", int'(out0 | out1), 0);
    chk("rst_mid_tick0", int'(tick0), 0);
    n = 0; c0 = 0;
    do begin
      step(1'b0, '0);
      n++;
      c0 += int'(out0 | out1);
    end while (!tick0 && n < 3 * MAX);
    chk("rst_to_tick", n, MAX);
    chk("rst_out_stays_low", c0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cur_p = PW'($urandom);
      if ($urandom_range(0, 29) == 0) cur_md = ~cur_md;
      ru = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      step($urandom_range(0, 149) == 0, ru);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
